// File: rtl/uart_rx_periph.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_periph                                               |
// | Description : Memory-mapped 8N1 UART receiver with a small RX FIFO,        |
// |               control/status register and a level interrupt.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_periph #(
  parameter int          BAUD_DIV = 5208,
  parameter int          FIFO_AW  = 2,
  parameter logic [31:0] ADDR_RXD = 32'h4000001C,
  parameter logic [31:0] ADDR_CON = 32'h40000020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rxd,
  output logic        irqout
);

  localparam int                c_CW    = $clog2(BAUD_DIV);
  localparam int                c_DEPTH = 2 ** FIFO_AW;
  localparam logic [c_CW-1:0]   c_HALF  = c_CW'(BAUD_DIV / 2 - 1);
  localparam logic [c_CW-1:0]   c_FULL  = c_CW'(BAUD_DIV - 1);
  localparam logic [FIFO_AW:0]  c_DEPTH_PTR = (FIFO_AW + 1)'(c_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]        r_bit, w_bit_nxt;
  logic [7:0]        r_sh, w_sh_nxt;
  logic              w_push_req;
  logic              w_ferr_set;

  logic              r_rx_s1, r_rx_s2, r_rx_prev;
  logic              w_fall;

  logic [7:0]        r_mem [c_DEPTH];
  logic [FIFO_AW:0]  r_wptr, r_rptr;
  logic [FIFO_AW:0]  w_count;
  logic              w_empty, w_full;
  logic              w_pop, w_push, w_ovr_set;
  logic [31:0]       w_count32;
  logic [2:0]        w_count3;

  logic              r_irq_en, r_ovr, r_ferr;
  logic              w_sel_rxd, w_sel_con, w_con_wr;
  logic              w_unused;

  // Bits of wdata that carry no function are intentionally ignored.
  assign w_unused = ^{wdata[31:4], wdata[1]};

  // Two-flop synchroniser plus a history flop for start-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s2;

  // Receiver state register: state, bit-period counter, bit index, shifter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_sh    <= w_sh_nxt;
    end
  end

  // Receiver next-state: half-period start check, then full-period sampling.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_sh_nxt    = r_sh;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_cnt_nxt   = c_HALF;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          if (!r_rx_s2) begin
            w_cnt_nxt   = c_FULL;
            w_bit_nxt   = 3'd0;
            w_state_nxt = S_DATA;
          end else begin
            // Start bit vanished by mid-bit: treat as a glitch.
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_sh_nxt  = {r_rx_s2, r_sh[7:1]};
          w_cnt_nxt = c_FULL;
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        if (r_cnt == '0) begin
          if (r_rx_s2) begin
            w_push_req = 1'b1;
          end else begin
            w_ferr_set = 1'b1;
          end
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_sel_rxd = (addr == ADDR_RXD);
  assign w_sel_con = (addr == ADDR_CON);
  assign w_con_wr  = wr & w_sel_con;

  assign w_count   = r_wptr - r_rptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == c_DEPTH_PTR);
  assign w_pop     = rd & w_sel_rxd & ~w_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovr_set = w_push_req & w_full & ~w_pop;

  assign w_count32 = 32'(w_count);
  assign w_count3  = (w_count32 > 32'd7) ? 3'd7 : w_count32[2:0];

  // FIFO storage; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wptr[FIFO_AW-1:0]] <= r_sh;
    end
  end

  // FIFO pointers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Control/status flags; a new error event outranks a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_irq_en <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      if (w_con_wr) r_irq_en <= wdata[0];
      if (w_ovr_set)                r_ovr <= 1'b1;
      else if (w_con_wr && wdata[2]) r_ovr <= 1'b0;
      if (w_ferr_set)               r_ferr <= 1'b1;
      else if (w_con_wr && wdata[3]) r_ferr <= 1'b0;
    end
  end

  // Combinational read mux, forced to zero while in reset.
  always_comb begin
    rdata = 32'd0;
    if (reset && rd) begin
      if (w_sel_rxd) begin
        rdata = w_empty ? 32'd0 : {24'd0, r_mem[r_rptr[FIFO_AW-1:0]]};
      end else if (w_sel_con) begin
        rdata = {25'd0, w_count3, r_ferr, r_ovr, ~w_empty, r_irq_en};
      end
    end
  end

  assign irqout = reset & r_irq_en & ~w_empty;

endmodule
`default_nettype wire
